uart_bus_responder: RTL and testbench

- Responder (device) end of the board UART parallel handshake used by uart_controller.
- Accepts active-low rdn/wrn strobes on an 8-bit data bus and reports status on data_ready, tbre and tsre, matching the board UART.
- Converts bytes to and from an 8N1 serial line on txd/rxd.
- Used as a synthesizable stand-in for the board UART and as the bus model in uart_controller benches.

---
 rtl/uart_bus_responder.sv | 212 +++++++++++++++++++++
 tb/tb_uart_bus_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_responder.sv
// Device end of the board UART parallel strobe interface, bridging bytes to and from an 8N1 line.
// Holding/shift registers on transmit; a single receive buffer with overrun and framing flags.
module uart_bus_responder #(
    parameter int unsigned CLKS_PER_BIT = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wrn,
    input  logic       rdn,
    input  logic [7:0] bus_din,
    output logic [7:0] bus_dout,
    output logic       bus_doe,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    output logic       txd,
    input  logic       rxd,
    output logic       tx_ovr,
    output logic       rx_ovr,
    output logic       frm_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic wrn_prev;
    logic rdn_prev;
    logic wr_edge;
    logic rd_edge;

    // Strobe history follows the pins even in reset, so a strobe held low across reset is not an edge.
    always_ff @(posedge clk) begin
        wrn_prev <= wrn;
        rdn_prev <= rdn;
    end

    assign wr_edge = wrn_prev & ~wrn;
    assign rd_edge = rdn_prev & ~rdn;

    state_t          tx_state;
    logic [7:0]      thr;
    logic [7:0]      tsr;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= IDLE;
            thr      <= '0;
            tsr      <= '0;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            txd      <= 1'b1;
            tbre     <= 1'b1;
            tsre     <= 1'b1;
            tx_ovr   <= 1'b0;
        end else begin
            if (wr_edge) begin
                if (tbre) begin
                    thr  <= bus_din;
                    tbre <= 1'b0;
                end else begin
                    tx_ovr <= 1'b1;
                end
            end
            case (tx_state)
                IDLE: begin
                    if (!tbre) begin
                        tsr      <= thr;
                        tbre     <= 1'b1;
                        tsre     <= 1'b0;
                        txd      <= 1'b0;
                        tx_cnt   <= '0;
                        tx_state <= START;
                    end
                end
                START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        txd      <= tsr[0];
                        tx_state <= DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            txd      <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                            tsr    <= {1'b0, tsr[7:1]};
                            txd    <= tsr[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        // A pending byte starts its frame straight from the stop bit, no idle gap.
                        if (!tbre) begin
                            tsr      <= thr;
                            tbre     <= 1'b1;
                            txd      <= 1'b0;
                            tx_state <= START;
                        end else begin
                            tsre     <= 1'b1;
                            tx_state <= IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    logic          rxd_s1;
    logic          rxd_s2;
    state_t        rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_sh;
    logic [7:0]    rbr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1     <= 1'b1;
            rxd_s2     <= 1'b1;
            rx_state   <= IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_sh      <= '0;
            rbr        <= '0;
            data_ready <= 1'b0;
            bus_dout   <= '0;
            bus_doe    <= 1'b0;
            rx_ovr     <= 1'b0;
            frm_err    <= 1'b0;
        end else begin
            rxd_s1  <= rxd;
            rxd_s2  <= rxd_s1;
            frm_err <= 1'b0;
            if (rd_edge) begin
                bus_dout   <= rbr;
                bus_doe    <= 1'b1;
                data_ready <= 1'b0;
            end else if (rdn) begin
                bus_doe <= 1'b0;
            end
            case (rx_state)
                IDLE: begin
                    if (!rxd_s2) begin
                        rx_cnt   <= '0;
                        rx_state <= START;
                    end
                end
                START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rxd_s2 ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rxd_s2, rx_sh[7:1]};
                        if (rx_idx == 3'd7) begin
                            rx_state <= STOP;
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
                        // Completion wins over a same-cycle read: the reader got the old byte above.
                        if (rxd_s2) begin
                            rbr        <= rx_sh;
                            data_ready <= 1'b1;
                            if (data_ready && !rd_edge) begin
                                rx_ovr <= 1'b1;
                            end
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Bench for uart_bus_responder: directed scenarios plus random traffic, checked through
// scoreboard queues drained by independent TX-line and read-bus monitors.
module tb_uart_bus_responder;

    localparam int unsigned CPB = 4;
    localparam int unsigned RX_DONE = 3 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wrn = 1'b1;
    logic       rdn = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] bus_din = '0;
    logic [7:0] bus_dout;
    logic       bus_doe;
    logic       data_ready;
    logic       tbre;
    logic       tsre;
    logic       txd;
    logic       tx_ovr;
    logic       rx_ovr;
    logic       frm_err;

    always #5 clk = ~clk;

    uart_bus_responder #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .wrn(wrn), .rdn(rdn),
        .bus_din(bus_din), .bus_dout(bus_dout), .bus_doe(bus_doe),
        .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .txd(txd),
        .rxd(rxd), .tx_ovr(tx_ovr), .rx_ovr(rx_ovr), .frm_err(frm_err)
    );

    typedef struct {
        logic [7:0] data;
        bit         chained;
        int         start_at;
    } tx_exp_t;

    int         checks = 0;
    int         errors = 0;
    int         ncnt = 0;
    int         frm_count = 0;
    tx_exp_t    tx_q[$];
    logic [7:0] rd_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line monitor: every frame must match the next queued byte level-for-level.
    initial begin : tx_mon
        logic       prev;
        logic [9:0] frame;
        logic [7:0] got;
        int         bad;
        int         det;
        int         last_end;
        tx_exp_t    e;
        prev = 1'b1;
        last_end = -10;
        forever begin
            @(negedge clk);
            ncnt++;
            if (prev === 1'b1 && txd === 1'b0) begin
                det = ncnt;
                bad = 0;
                got = '0;
                e.data = 8'h00;
                e.chained = 1'b0;
                e.start_at = -1;
                check("tx_frame_expected", tx_q.size() > 0, 1);
                if (tx_q.size() > 0) e = tx_q.pop_front();
                frame = {1'b1, e.data, 1'b0};
                for (int k = 0; k < 10 * CPB; k++) begin
                    if (k > 0) begin
                        @(negedge clk);
                        ncnt++;
                    end
                    if (txd !== frame[k / CPB]) bad++;
                    if (k / CPB >= 1 && k / CPB <= 8 && k % CPB == CPB / 2) got[k / CPB - 1] = txd;
                end
                check("tx_frame_byte", got, e.data);
                check("tx_frame_shape", bad, 0);
                if (e.chained) check("tx_back_to_back", det, last_end + 1);
                if (e.start_at >= 0) check("tx_start_latency", det, e.start_at);
                last_end = ncnt;
            end
            prev = txd;
        end
    end

    initial begin : rx_mon
        logic       prev_doe;
        logic [7:0] e;
        prev_doe = 1'b0;
        forever begin
            @(negedge clk);
            if (frm_err === 1'b1) frm_count++;
            if (bus_doe === 1'b1 && prev_doe !== 1'b1) begin
                check("read_expected", rd_q.size() > 0, 1);
                if (rd_q.size() > 0) begin
                    e = rd_q.pop_front();
                    check("bus_dout", bus_dout, e);
                end
            end
            prev_doe = bus_doe;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic do_write(input logic [7:0] b, input bit expect_frame, input bit chained, input bit timed);
        tx_exp_t e;
        @(posedge clk);
        #1 wrn = 1'b0;
        bus_din = b;
        e.data = b;
        e.chained = chained;
        e.start_at = timed ? ncnt + 3 : -1;
        if (expect_frame) tx_q.push_back(e);
        @(posedge clk);
        #1 wrn = 1'b1;
    endtask

    task automatic do_read(input logic [7:0] exp);
        rd_q.push_back(exp);
        @(posedge clk);
        #1 rdn = 1'b0;
        @(posedge clk);
        #1 rdn = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(posedge clk);
        #1 rxd = f[0];
        for (int i = 1; i < 10; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rxd = f[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while (!(tbre === 1'b1 && tsre === 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("tx_idle_timeout", n < 500, 1);
    endtask

    initial begin
        int         fc;
        logic [7:0] b;

        // Reset with the write strobe held low across release
        wrn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_tbre", tbre, 1);
        check("rst_tsre", tsre, 1);
        check("rst_data_ready", data_ready, 0);
        check("rst_bus_doe", bus_doe, 0);
        check("rst_bus_dout", bus_dout, 0);
        check("rst_tx_ovr", tx_ovr, 0);
        check("rst_rx_ovr", rx_ovr, 0);
        check("rst_frm_err", frm_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("held_wrn_tbre", tbre, 1);
        check("held_wrn_tsre", tsre, 1);
        check("held_wrn_txd", txd, 1);
        wrn = 1'b1;
        repeat (2) @(posedge clk);

        // Single write 0xA5
        do_write(8'hA5, 1'b1, 1'b0, 1'b1);
        check("tbre_after_write", tbre, 0);
        @(posedge clk);
        #1;
        check("tbre_after_transfer", tbre, 1);
        check("tsre_busy", tsre, 0);
        wait_tx_idle();

        // Back-to-back frames, then a write into a full holding register
        do_write(8'h3C, 1'b1, 1'b0, 1'b0);
        do_write(8'hC3, 1'b1, 1'b1, 1'b0);
        do_write(8'hE7, 1'b0, 1'b0, 1'b0);
        check("tx_ovr_set", tx_ovr, 1);
        check("tbre_full", tbre, 0);
        wait_tx_idle();

        // Receive and read 0x5A
        send_rx(8'h5A, 1'b1);
        check("rx_ready_5a", data_ready, 1);
        do_read(8'h5A);
        check("ready_cleared_5a", data_ready, 0);
        check("doe_during_read", bus_doe, 1);
        @(posedge clk);
        #1;
        check("doe_dropped", bus_doe, 0);

        // Overrun, framing error, glitch
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        check("rx_ovr_set", rx_ovr, 1);
        check("rx_ready_22", data_ready, 1);
        do_read(8'h22);
        check("ready_cleared_22", data_ready, 0);
        fc = frm_count;
        send_rx(8'h99, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("frm_err_pulses", frm_count - fc, 1);
        check("frm_ready_unchanged", data_ready, 0);
        @(posedge clk);
        #1 rxd = 1'b0;
        @(posedge clk);
        #1 rxd = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("glitch_no_byte", data_ready, 0);
        check("glitch_no_frm_err", frm_count - fc, 1);

        // Read edge coinciding with receive completion
        wait_tx_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst2_rx_ovr", rx_ovr, 0);
        check("rst2_tx_ovr", tx_ovr, 0);
        send_rx(8'h66, 1'b1);
        check("rx_ready_66", data_ready, 1);
        rd_q.push_back(8'h66);
        fork
            send_rx(8'h77, 1'b1);
            begin
                @(posedge clk);
                repeat (RX_DONE - 1) @(posedge clk);
                #1 rdn = 1'b0;
                @(posedge clk);
                #1 rdn = 1'b1;
            end
        join
        check("coincide_ready", data_ready, 1);
        check("coincide_no_ovr", rx_ovr, 0);
        do_read(8'h77);
        check("ready_cleared_77", data_ready, 0);

        // Random traffic in both directions
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                wait_tx_idle();
                do_write(b, 1'b1, 1'b0, 1'b0);
            end else begin
                send_rx(b, 1'b1);
                check("rand_rx_ready", data_ready, 1);
                do_read(b);
                check("rand_ready_cleared", data_ready, 0);
            end
        end

        wait_tx_idle();
        repeat (4) @(posedge clk);
        #1;
        check("tx_queue_drained", tx_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);
        check("final_tx_ovr", tx_ovr, 0);
        check("final_rx_ovr", rx_ovr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
